// File: rtl/boot_check_pkg.sv
// Shared state encoding, error codes and the CRC-32 word step used by the
// boot image checker and its CRC accumulator.
package boot_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROM    = 3'd1,
        ST_DROM    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_GOOD    = 3'd5,
        ST_BAD     = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_COUNT = 2'd1;
    localparam logic [1:0] ERR_ORDER = 2'd2;
    localparam logic [1:0] ERR_CRC   = 2'd3;

    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

    // Reflected CRC: bytes LSB first and bits LSB first collapse into
    // shifting the whole word out from bit 0 upward.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc_in,
                                               input logic [31:0] word);
        logic [31:0] c;
        c = crc_in ^ word;
        for (int i = 0; i < 32; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_accum.sv
// Registered CRC-32 accumulator: one 32-bit word per enabled cycle.
module crc32_accum
    import boot_check_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    output logic [31:0] crc_raw_o,
    output logic [31:0] crc_final_o
);

    logic [31:0] r_crc;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_crc <= CRC_INIT;
        end else if (en_i) begin
            r_crc <= crc32_word(r_crc, data_i);
        end
    end

    assign crc_raw_o   = r_crc;
    assign crc_final_o = r_crc ^ CRC_XOROUT;

endmodule

// File: rtl/boot_image_checker.sv
// Snoops the ROM loader write stream, counts and CRCs the image, and holds
// the core in reset until the trailer CRC matches.
module boot_image_checker
    import boot_check_pkg::*;
#(
    parameter logic [15:0] PROM_WORDS    = 16'd4096,
    parameter logic [15:0] DROM_WORDS    = 16'd2048,
    parameter bit          CHECK_ENABLE  = 1'b1,
    parameter logic [3:0]  RELEASE_DELAY = 4'd8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rom_acc_i,
    input  logic        prom_wr_en_i,
    input  logic        drom_wr_en_i,
    input  logic [31:0] rom_data_i,
    input  logic        loader_done_i,
    output logic        core_rst_o,
    output logic        image_ok_o,
    output logic        image_bad_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] word_count_o,
    output logic [31:0] crc_o,
    output logic [2:0]  dbg_state_o
);

    state_t      r_state;
    logic [15:0] r_prom_cnt;
    logic [15:0] r_drom_cnt;
    logic [15:0] r_word_cnt;
    logic [31:0] r_trailer;
    logic        r_trailer_seen;
    logic [3:0]  r_rel_cnt;
    logic        r_core_rst;
    logic        r_ok;
    logic        r_bad;
    logic [1:0]  r_err;

    logic        w_active;
    logic        w_both;
    logic        w_prom_ok;
    logic        w_drom_ok;
    logic [15:0] w_drom_idx;
    logic        w_is_trailer;
    logic        w_accept;
    logic        w_crc_en;
    logic        w_strobe_err;
    logic [1:0]  w_strobe_code;
    logic        w_trailer_now;
    logic        w_fail;
    logic [1:0]  w_fail_code;
    logic [31:0] w_crc_raw;
    logic [31:0] w_crc_final;

    assign w_active   = (r_state == ST_IDLE) || (r_state == ST_PROM) || (r_state == ST_DROM);
    assign w_both     = prom_wr_en_i && drom_wr_en_i;
    assign w_prom_ok  = (r_state == ST_IDLE) ||
                        ((r_state == ST_PROM) && (r_prom_cnt < PROM_WORDS));
    assign w_drom_ok  = ((r_state == ST_PROM) && (r_prom_cnt == PROM_WORDS)) ||
                        ((r_state == ST_DROM) && !r_trailer_seen);
    assign w_drom_idx = (r_state == ST_PROM) ? 16'd0 : r_drom_cnt;

    assign w_accept = w_active && !w_both &&
                      ((prom_wr_en_i && w_prom_ok) || (drom_wr_en_i && w_drom_ok));
    // The last DROM word is the expected CRC, so it never enters the CRC.
    assign w_is_trailer  = w_accept && drom_wr_en_i && (w_drom_idx == DROM_WORDS - 16'd1);
    assign w_crc_en      = w_accept && !w_is_trailer;
    assign w_strobe_err  = w_active && (prom_wr_en_i || drom_wr_en_i) && !w_accept;
    assign w_trailer_now = r_trailer_seen || w_is_trailer;

    always_comb begin
        w_strobe_code = ERR_ORDER;
        if (!w_both) begin
            if (prom_wr_en_i) begin
                w_strobe_code = (r_state == ST_PROM) ? ERR_COUNT : ERR_ORDER;
            end else if (drom_wr_en_i) begin
                w_strobe_code = (r_state == ST_IDLE) ? ERR_ORDER : ERR_COUNT;
            end
        end
    end

    always_comb begin
        w_fail      = 1'b0;
        w_fail_code = ERR_NONE;
        if (w_active && CHECK_ENABLE) begin
            if (w_strobe_err) begin
                w_fail      = 1'b1;
                w_fail_code = w_strobe_code;
            end else if (loader_done_i && !w_trailer_now) begin
                w_fail      = 1'b1;
                w_fail_code = ERR_COUNT;
            end else if (!loader_done_i && !rom_acc_i && (r_state != ST_IDLE)) begin
                w_fail      = 1'b1;
                w_fail_code = ERR_COUNT;
            end
        end
    end

    crc32_accum u_crc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (1'b0),
        .en_i        (w_crc_en),
        .data_i      (rom_data_i),
        .crc_raw_o   (w_crc_raw),
        .crc_final_o (w_crc_final)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_prom_cnt     <= 16'd0;
            r_drom_cnt     <= 16'd0;
            r_word_cnt     <= 16'd0;
            r_trailer      <= 32'd0;
            r_trailer_seen <= 1'b0;
            r_rel_cnt      <= 4'd0;
            r_core_rst     <= 1'b1;
            r_ok           <= 1'b0;
            r_bad          <= 1'b0;
            r_err          <= ERR_NONE;
        end else begin
            if (w_accept) begin
                if (r_word_cnt != 16'hFFFF) begin
                    r_word_cnt <= r_word_cnt + 16'd1;
                end
                if (prom_wr_en_i) begin
                    r_prom_cnt <= r_prom_cnt + 16'd1;
                end else begin
                    r_drom_cnt <= w_drom_idx + 16'd1;
                end
                if (w_is_trailer) begin
                    r_trailer      <= rom_data_i;
                    r_trailer_seen <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE, ST_PROM, ST_DROM: begin
                    if (w_fail) begin
                        r_state <= ST_BAD;
                        r_bad   <= 1'b1;
                        r_err   <= w_fail_code;
                    end else if (loader_done_i) begin
                        if (CHECK_ENABLE) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state   <= ST_RELEASE;
                            r_ok      <= 1'b1;
                            r_rel_cnt <= 4'd0;
                        end
                    end else if (w_accept && (r_state == ST_IDLE)) begin
                        r_state <= ST_PROM;
                    end else if (w_accept && drom_wr_en_i && (r_state == ST_PROM)) begin
                        r_state <= ST_DROM;
                    end
                end
                ST_CHECK: begin
                    if (w_crc_final == r_trailer) begin
                        r_state   <= ST_RELEASE;
                        r_ok      <= 1'b1;
                        r_rel_cnt <= 4'd0;
                    end else begin
                        r_state <= ST_BAD;
                        r_bad   <= 1'b1;
                        r_err   <= ERR_CRC;
                    end
                end
                ST_RELEASE: begin
                    if (r_rel_cnt == RELEASE_DELAY) begin
                        r_core_rst <= 1'b0;
                        r_state    <= ST_GOOD;
                    end else begin
                        r_rel_cnt <= r_rel_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign core_rst_o   = r_core_rst;
    assign image_ok_o   = r_ok;
    assign image_bad_o  = r_bad;
    assign err_code_o   = r_err;
    assign word_count_o = r_word_cnt;
    assign crc_o        = w_crc_final;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_boot_image_checker.sv
// Directed bench for boot_image_checker: three instances with different
// parameters, a CRC reference model and an expected-value queue.
module tb_boot_image_checker;

    logic        clk;
    logic        rst      [3];
    logic        rom_acc  [3];
    logic        prom     [3];
    logic        drom     [3];
    logic [31:0] data     [3];
    logic        done     [3];
    logic        core_rst [3];
    logic        ok       [3];
    logic        bad      [3];
    logic [1:0]  err      [3];
    logic [15:0] wc       [3];
    logic [31:0] crc      [3];
    logic [2:0]  st       [3];

    int          n_total;
    int          n_bad;
    logic [47:0] exp_q[$];
    int          m_cnt;
    logic [31:0] m_crc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    boot_image_checker #(.PROM_WORDS(16'd1), .DROM_WORDS(16'd1), .CHECK_ENABLE(1'b1),
                         .RELEASE_DELAY(4'd8)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .rom_acc_i(rom_acc[0]), .prom_wr_en_i(prom[0]),
        .drom_wr_en_i(drom[0]), .rom_data_i(data[0]), .loader_done_i(done[0]),
        .core_rst_o(core_rst[0]), .image_ok_o(ok[0]), .image_bad_o(bad[0]),
        .err_code_o(err[0]), .word_count_o(wc[0]), .crc_o(crc[0]), .dbg_state_o(st[0]));

    boot_image_checker #(.PROM_WORDS(16'd4), .DROM_WORDS(16'd2), .CHECK_ENABLE(1'b1),
                         .RELEASE_DELAY(4'd0)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .rom_acc_i(rom_acc[1]), .prom_wr_en_i(prom[1]),
        .drom_wr_en_i(drom[1]), .rom_data_i(data[1]), .loader_done_i(done[1]),
        .core_rst_o(core_rst[1]), .image_ok_o(ok[1]), .image_bad_o(bad[1]),
        .err_code_o(err[1]), .word_count_o(wc[1]), .crc_o(crc[1]), .dbg_state_o(st[1]));

    boot_image_checker #(.PROM_WORDS(16'd1), .DROM_WORDS(16'd1), .CHECK_ENABLE(1'b0),
                         .RELEASE_DELAY(4'd8)) u_dut2 (
        .clk_i(clk), .rst_i(rst[2]), .rom_acc_i(rom_acc[2]), .prom_wr_en_i(prom[2]),
        .drom_wr_en_i(drom[2]), .rom_data_i(data[2]), .loader_done_i(done[2]),
        .core_rst_o(core_rst[2]), .image_ok_o(ok[2]), .image_bad_o(bad[2]),
        .err_code_o(err[2]), .word_count_o(wc[2]), .crc_o(crc[2]), .dbg_state_o(st[2]));

    // Byte-at-a-time reference CRC, LSB byte first, reflected.
    function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [31:0] w);
        logic [31:0] c;
        logic [7:0]  b;
        c = c_in;
        for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            c = c ^ {24'd0, b};
            for (int j = 0; j < 8; j++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                else      c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_crc = 32'hFFFFFFFF;
        exp_q.delete();
    endtask

    task automatic reset_dut(input int d);
        @(negedge clk);
        rst[d] = 1'b1; rom_acc[d] = 1'b0; prom[d] = 1'b0; drom[d] = 1'b0;
        done[d] = 1'b0; data[d] = 32'd0;
        @(negedge clk);
        rst[d] = 1'b0;
        model_reset();
    endtask

    // kind: 0 = strobe must be rejected, 1 = data word, 2 = trailer word
    task automatic drive(input int d, input bit is_prom, input bit both,
                         input logic [31:0] w, input int kind, input string tag);
        logic [47:0] e;
        @(negedge clk);
        data[d] = w;
        prom[d] = is_prom | both;
        drom[d] = !is_prom | both;
        if (kind == 1) begin
            m_crc = crc_model(m_crc, w);
            m_cnt++;
        end else if (kind == 2) begin
            m_cnt++;
        end
        exp_q.push_back({m_cnt[15:0], m_crc ^ 32'hFFFFFFFF});
        @(negedge clk);
        prom[d] = 1'b0;
        drom[d] = 1'b0;
        data[d] = $urandom();
        e = exp_q.pop_front();
        chk({tag, "_wc"}, {16'd0, wc[d]}, {16'd0, e[47:32]});
        chk({tag, "_crc"}, crc[d], e[31:0]);
    endtask

    task automatic chk_reset_vals(input int d, input string tag);
        chk({tag, "_core_rst"}, {31'd0, core_rst[d]}, 32'd1);
        chk({tag, "_ok"}, {31'd0, ok[d]}, 32'd0);
        chk({tag, "_bad"}, {31'd0, bad[d]}, 32'd0);
        chk({tag, "_err"}, {30'd0, err[d]}, 32'd0);
        chk({tag, "_wc"}, {16'd0, wc[d]}, 32'd0);
        chk({tag, "_crc"}, crc[d], 32'd0);
    endtask

    initial begin
        int hit;
        logic [31:0] w;
        n_total = 0;
        n_bad   = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; rom_acc[d] = 1'b0; prom[d] = 1'b0; drom[d] = 1'b0;
            data[d] = 32'd0; done[d] = 1'b0;
        end
        tick(3);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        model_reset();
        chk_reset_vals(0, "rst0");

        // Good image: zero word, trailer is CRC of four zero bytes
        rom_acc[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h00000000, 1, "good_prom");
        chk("good_crc_const", crc[0], 32'h2144DF1C);
        drive(0, 1'b0, 1'b0, 32'h2144DF1C, 2, "good_trl");
        done[0] = 1'b1;
        tick(1);
        chk("good_ok_early", {31'd0, ok[0]}, 32'd0);
        tick(1);
        chk("good_ok", {31'd0, ok[0]}, 32'd1);
        chk("good_err", {30'd0, err[0]}, 32'd0);
        tick(7);
        chk("good_core_held", {31'd0, core_rst[0]}, 32'd1);
        tick(2);
        chk("good_core_rel", {31'd0, core_rst[0]}, 32'd0);
        chk("good_bad", {31'd0, bad[0]}, 32'd0);
        chk("good_state", {29'd0, st[0]}, 32'd5);
        drive(0, 1'b1, 1'b0, 32'h12345678, 0, "good_frozen");

        // CRC error: trailer off by one bit
        reset_dut(0);
        rom_acc[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h00000000, 1, "crcerr_prom");
        drive(0, 1'b0, 1'b0, 32'h2144DF1D, 2, "crcerr_trl");
        done[0] = 1'b1;
        tick(2);
        chk("crcerr_bad", {31'd0, bad[0]}, 32'd1);
        chk("crcerr_err", {30'd0, err[0]}, 32'd3);
        chk("crcerr_ok", {31'd0, ok[0]}, 32'd0);
        hit = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (core_rst[0] !== 1'b1) hit++;
        end
        chk("crcerr_core_held", hit, 32'd0);

        // Short image: three of four prom words then a drom strobe
        reset_dut(1);
        rom_acc[1] = 1'b1;
        for (int i = 0; i < 3; i++) drive(1, 1'b1, 1'b0, $urandom(), 1, "short_prom");
        drive(1, 1'b0, 1'b0, $urandom(), 0, "short_drom");
        chk("short_bad", {31'd0, bad[1]}, 32'd1);
        chk("short_err", {30'd0, err[1]}, 32'd1);
        drive(1, 1'b1, 1'b0, $urandom(), 0, "short_frozen");

        // Order error: prom strobe while in DROM
        reset_dut(1);
        rom_acc[1] = 1'b1;
        for (int i = 0; i < 4; i++) drive(1, 1'b1, 1'b0, $urandom(), 1, "ord_prom");
        drive(1, 1'b0, 1'b0, $urandom(), 1, "ord_drom");
        drive(1, 1'b1, 1'b0, $urandom(), 0, "ord_late_prom");
        chk("ord_err", {30'd0, err[1]}, 32'd2);
        chk("ord_core", {31'd0, core_rst[1]}, 32'd1);

        // Order error: both strobes together in PROM
        reset_dut(1);
        rom_acc[1] = 1'b1;
        drive(1, 1'b1, 1'b0, $urandom(), 1, "both_prom");
        drive(1, 1'b1, 1'b1, $urandom(), 0, "both_strobe");
        chk("both_err", {30'd0, err[1]}, 32'd2);

        // loader_done with nothing loaded
        reset_dut(1);
        done[1] = 1'b1;
        tick(1);
        chk("empty_bad", {31'd0, bad[1]}, 32'd1);
        chk("empty_err", {30'd0, err[1]}, 32'd1);

        // rom_acc dropped mid-load
        reset_dut(1);
        rom_acc[1] = 1'b1;
        drive(1, 1'b1, 1'b0, $urandom(), 1, "acc_prom");
        rom_acc[1] = 1'b0;
        tick(1);
        chk("acc_err", {30'd0, err[1]}, 32'd1);

        // Reset mid-load, then a full valid reload with zero release delay
        reset_dut(1);
        rom_acc[1] = 1'b1;
        for (int i = 0; i < 2; i++) drive(1, 1'b1, 1'b0, $urandom(), 1, "mid_prom");
        rst[1] = 1'b1;
        tick(1);
        chk_reset_vals(1, "mid_rst");
        rst[1] = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) drive(1, 1'b1, 1'b0, $urandom(), 1, "rel_prom");
        drive(1, 1'b0, 1'b0, $urandom(), 1, "rel_drom");
        w = m_crc ^ 32'hFFFFFFFF;
        drive(1, 1'b0, 1'b0, w, 2, "rel_trl");
        done[1] = 1'b1;
        tick(2);
        chk("rel_ok", {31'd0, ok[1]}, 32'd1);
        chk("rel_core_held", {31'd0, core_rst[1]}, 32'd1);
        tick(1);
        chk("rel_core_rel", {31'd0, core_rst[1]}, 32'd0);
        chk("rel_wc", {16'd0, wc[1]}, 32'd6);

        // Checks disabled: wrong trailer still releases the core
        reset_dut(2);
        rom_acc[2] = 1'b1;
        drive(2, 1'b1, 1'b0, 32'h00000000, 1, "noce_prom");
        drive(2, 1'b0, 1'b0, 32'hDEADBEEF, 2, "noce_trl");
        done[2] = 1'b1;
        for (int i = 0; i < 10 && ok[2] !== 1'b1; i++) @(negedge clk);
        chk("noce_ok", {31'd0, ok[2]}, 32'd1);
        chk("noce_bad", {31'd0, bad[2]}, 32'd0);
        chk("noce_err", {30'd0, err[2]}, 32'd0);
        for (int i = 0; i < 20 && core_rst[2] !== 1'b0; i++) @(negedge clk);
        chk("noce_core_rel", {31'd0, core_rst[2]}, 32'd0);
        chk("noce_crc", crc[2], 32'h2144DF1C);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/boot_image_checker.md
Name: boot_image_checker

Overview:
- Sits between irom_loader and riscv32 in the board top level.
- Snoops the loader's ROM write stream: rom_acc, prom_wr_en, drom_wr_en and the 32-bit rom_data.
- Counts the PROM and DROM words, runs a CRC-32 over the stream and compares it against a trailer word.
- Holds the core in reset until the image is validated, so a corrupt or short flash image never executes and the failure is reported.

Parameters:
PROM_WORDS, 16'd4096, number of instruction words expected before the first DROM word.
DROM_WORDS, 16'd2048, number of DROM words including the trailer word; minimum 1.
CHECK_ENABLE, 1, 1 = enforce count and CRC checks; 0 = release the core on loader_done_i alone.
RELEASE_DELAY, 4'd8, clk_i cycles between image_ok_o asserting and core_rst_o deasserting; 0 is legal.

Ports:
clk_i  in  1  system clock (the clk_i domain)
rst_i  in  1  synchronous, active-high reset
rom_acc_i  in  1  loader owns the ROMs
prom_wr_en_i  in  1  one-cycle strobe per PROM word
drom_wr_en_i  in  1  one-cycle strobe per DROM word
rom_data_i  in  32  word accompanying the strobe
loader_done_i  in  1  loader finished; level signal
core_rst_o  out  1  active-high reset to riscv32
image_ok_o  out  1  image validated (sticky)
image_bad_o  out  1  image rejected (sticky)
err_code_o  out  2  0 none, 1 count, 2 order, 3 crc
word_count_o  out  16  total words accepted; saturates at 16'hFFFF
crc_o  out  32  running CRC (final-xored) over data words; the trailer word is excluded

Behaviour:
- Reset (rst_i high at a clk_i edge), all registered outputs:
  - core_rst_o=1; image_ok_o=0; image_bad_o=0; err_code_o=0; word_count_o=0; crc_o=32'h00000000.
  - Internal CRC state = 32'hFFFFFFFF; FSM = IDLE.
  - rst_i mid-load aborts everything identically.
- CRC definition: CRC-32, reflected, polynomial 32'hEDB88320, init FFFFFFFF, xorout FFFFFFFF.
  - Each word is processed as 4 bytes, LSB byte first.
  - One word per cycle.
- FSM states: IDLE, PROM, DROM, CHECK, RELEASE, GOOD, BAD.
- IDLE:
  - A prom_wr_en_i strobe → PROM; that word is counted and CRCed.
  - A drom_wr_en_i strobe → BAD with err 2.
  - loader_done_i → BAD with err 1.
- PROM:
  - Each prom strobe: count+1, CRC update.
  - A drom strobe when prom count == PROM_WORDS → DROM and process that word.
  - A drom strobe when prom count != PROM_WORDS → BAD with err 1.
  - A prom strobe beyond PROM_WORDS → BAD with err 1.
- DROM:
  - Words 0..DROM_WORDS-2 update the CRC.
  - Word DROM_WORDS-1 is the trailer: it is latched, not CRCed, and not added to crc_o.
  - Any further drom strobe, or any prom strobe → BAD (err 1 and err 2 respectively).
- Simultaneous prom and drom strobes in any state → BAD with err 2.
- loader_done_i in PROM or DROM:
  - Trailer already received → CHECK.
  - Otherwise → BAD with err 1.
- CHECK (one cycle):
  - final CRC == trailer → RELEASE, image_ok_o=1 on the following edge.
  - Otherwise → BAD with err 3.
  - image_ok_o/image_bad_o therefore assert exactly 2 cycles after loader_done_i is first sampled high.
- RELEASE:
  - Counts RELEASE_DELAY cycles, then core_rst_o=0 and → GOOD.
  - RELEASE_DELAY=0: core_rst_o drops on the edge after image_ok_o rises.
- GOOD and BAD are terminal until rst_i.
  - All strobes are ignored; word_count_o and crc_o freeze.
  - BAD keeps core_rst_o=1 permanently.
- CHECK_ENABLE=0:
  - Counting and CRC still run and are reported.
  - No error transitions are taken; loader_done_i goes straight to RELEASE with image_ok_o=1.
- rom_acc_i is informational only. Its deassertion before loader_done_i while in PROM or DROM → BAD with err 1.
- rom_data_i is sampled only when a strobe is high.

Decomposition:
- Package boot_check_pkg holds:
  - the state encoding;
  - the err code constants;
  - CRC_POLY, CRC_INIT, CRC_XOROUT;
  - the pure function crc32_word(crc_in, word) that unrolls the 32 bit-steps.
- One sub-module, crc32_accum: a registered CRC with clear, enable and 32-bit data, exposing raw and final-xored values.
- The FSM, counters and release timer stay in boot_image_checker.

Test Plan:
- Good image: PROM_WORDS=1, DROM_WORDS=1. Prom 32'h00000000, drom trailer 32'h2144DF1C, then loader_done_i → crc_o=32'h2144DF1C, image_ok_o=1 at +2 cycles, core_rst_o=0 after RELEASE_DELAY=8 more cycles, err_code_o=0.
- CRC error: same image with trailer 32'h2144DF1D → image_bad_o=1, err_code_o=3, core_rst_o stays 1 for 1000 cycles.
- Short image: PROM_WORDS=4, only 3 prom words then a drom strobe → BAD with err 1, word_count_o=3.
- Order error: in DROM, inject a prom strobe; separately, assert both strobes in the same cycle → err_code_o=2 in each case.
- Reset mid-load: assert rst_i after 2 words → outputs return to reset values next edge; a full valid reload then reaches GOOD.
- CHECK_ENABLE=0 with a wrong trailer → image_ok_o=1, core_rst_o released, crc_o still reports the computed value.
